// File: rtl/kernel_pkg.sv
// rtl/kernel_pkg.sv - select codes, FSM states and step decode for the kernel window sequencer
package kernel_pkg;

  localparam logic [3:0] SEL_NONE = 4'b0000;
  localparam logic [3:0] SEL_TL   = 4'b0001;
  localparam logic [3:0] SEL_TR   = 4'b0010;
  localparam logic [3:0] SEL_BL   = 4'b0011;
  localparam logic [3:0] SEL_BR   = 4'b0100;
  localparam logic [3:0] SEL_R    = 4'b0101;
  localparam logic [3:0] SEL_L    = 4'b0110;
  localparam logic [3:0] SEL_T    = 4'b0111;
  localparam logic [3:0] SEL_B    = 4'b1000;
  localparam logic [3:0] SEL_C    = 4'b1111;

  localparam logic [3:0] LAST_STEP = 4'd8;

  typedef enum logic {ACCEPT, SEQ} state_t;

  // Corners first, then edges, centre last so the centre closes the window.
  function automatic logic [3:0] step_sel(input logic [3:0] step);
    logic [3:0] sel;
    sel = SEL_NONE;
    case (step)
      4'd0:    sel = SEL_TL;
      4'd1:    sel = SEL_TR;
      4'd2:    sel = SEL_BL;
      4'd3:    sel = SEL_BR;
      4'd4:    sel = SEL_R;
      4'd5:    sel = SEL_L;
      4'd6:    sel = SEL_T;
      4'd7:    sel = SEL_B;
      4'd8:    sel = SEL_C;
      default: sel = SEL_NONE;
    endcase
    return sel;
  endfunction

endpackage

// File: rtl/kernel_line_buf.sv
// rtl/kernel_line_buf.sv - one image row of pixels, read and written at the same column index
module kernel_line_buf #(
  parameter int PIX_W = 3,
  parameter int IMG_W = 8,
  localparam int AW   = $clog2(IMG_W)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             we,
  input  logic [AW-1:0]    idx,
  input  logic [PIX_W-1:0] wdata,
  output logic [PIX_W-1:0] rdata
);

  logic [PIX_W-1:0] mem_q [IMG_W];
  logic [PIX_W-1:0] mem_d [IMG_W];

  always_comb begin
    mem_d = mem_q;
    if (we) begin
      mem_d[idx] = wdata;
    end
  end

  // Read returns the pre-write value, i.e. the pixel from the previous row.
  assign rdata = mem_q[idx];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mem_q <= '{default: '0};
    end else begin
      mem_q <= mem_d;
    end
  end

endmodule

// File: rtl/kernel_window_seq.sv
// rtl/kernel_window_seq.sv - builds 3x3 windows from a raster stream and steps the demux select per tap
module kernel_window_seq
  import kernel_pkg::*;
#(
  parameter int PIX_W = 3,
  parameter int IMG_W = 8,
  parameter int IMG_H = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [PIX_W-1:0] in_pix,
  input  logic             in_valid,
  output logic             in_ready,
  output logic [PIX_W-1:0] tl_d,
  output logic [PIX_W-1:0] t_d,
  output logic [PIX_W-1:0] tr_d,
  output logic [PIX_W-1:0] l_d,
  output logic [PIX_W-1:0] c_d,
  output logic [PIX_W-1:0] r_d,
  output logic [PIX_W-1:0] bl_d,
  output logic [PIX_W-1:0] b_d,
  output logic [PIX_W-1:0] br_d,
  output logic [3:0]       select,
  output logic             win_valid,
  input  logic             out_ready,
  output logic             win_last,
  output logic             frame_done
);

  localparam int CW = $clog2(IMG_W);
  localparam int RW = $clog2(IMG_H);
  localparam logic [CW-1:0] COL_MAX = CW'(IMG_W - 1);
  localparam logic [RW-1:0] ROW_MAX = RW'(IMG_H - 1);

  state_t           state_q, state_d;
  logic [RW-1:0]    row_q, row_d;
  logic [CW-1:0]    col_q, col_d;
  logic [3:0]       step_q, step_d;
  logic             last_win_q, last_win_d;
  logic [PIX_W-1:0] w_q [3][3];
  logic [PIX_W-1:0] w_d [3][3];
  logic             in_ready_q, in_ready_d;
  logic             win_valid_q, win_valid_d;
  logic [3:0]       select_q, select_d;
  logic             win_last_q, win_last_d;
  logic             frame_done_q, frame_done_d;

  logic             accept;
  logic [PIX_W-1:0] lb0_rd, lb1_rd;

  assign accept = (state_q == ACCEPT) && in_valid;

  kernel_line_buf #(.PIX_W(PIX_W), .IMG_W(IMG_W)) u_lb0 (
    .clk   (clk),
    .rst_n (rst_n),
    .we    (accept),
    .idx   (col_q),
    .wdata (in_pix),
    .rdata (lb0_rd)
  );

  kernel_line_buf #(.PIX_W(PIX_W), .IMG_W(IMG_W)) u_lb1 (
    .clk   (clk),
    .rst_n (rst_n),
    .we    (accept),
    .idx   (col_q),
    .wdata (lb0_rd),
    .rdata (lb1_rd)
  );

  always_comb begin
    state_d    = state_q;
    row_d      = row_q;
    col_d      = col_q;
    step_d     = step_q;
    last_win_d = last_win_q;
    w_d        = w_q;

    case (state_q)
      ACCEPT: begin
        if (accept) begin
          for (int r = 0; r < 3; r++) begin
            w_d[r][0] = w_q[r][1];
            w_d[r][1] = w_q[r][2];
          end
          w_d[0][2] = lb1_rd;
          w_d[1][2] = lb0_rd;
          w_d[2][2] = in_pix;

          if (col_q == COL_MAX) begin
            col_d = '0;
            row_d = (row_q == ROW_MAX) ? '0 : row_q + RW'(1);
          end else begin
            col_d = col_q + CW'(1);
          end

          // Windows straddling a row start would mix stale columns; only col>=2 is issued.
          if ((row_q >= RW'(2)) && (col_q >= CW'(2))) begin
            state_d    = SEQ;
            step_d     = '0;
            last_win_d = (row_q == ROW_MAX) && (col_q == COL_MAX);
          end
        end
      end
      SEQ: begin
        if (out_ready) begin
          if (step_q == LAST_STEP) begin
            state_d = ACCEPT;
          end else begin
            step_d = step_q + 4'd1;
          end
        end
      end
      default: state_d = ACCEPT;
    endcase

    in_ready_d   = (state_d == ACCEPT);
    win_valid_d  = (state_d == SEQ);
    select_d     = win_valid_d ? step_sel(step_d) : SEL_NONE;
    win_last_d   = win_valid_d && (step_d == LAST_STEP);
    frame_done_d = win_last_d && last_win_d;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= ACCEPT;
      row_q        <= '0;
      col_q        <= '0;
      step_q       <= '0;
      last_win_q   <= 1'b0;
      w_q          <= '{default: '0};
      in_ready_q   <= 1'b1;
      win_valid_q  <= 1'b0;
      select_q     <= SEL_NONE;
      win_last_q   <= 1'b0;
      frame_done_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      row_q        <= row_d;
      col_q        <= col_d;
      step_q       <= step_d;
      last_win_q   <= last_win_d;
      w_q          <= w_d;
      in_ready_q   <= in_ready_d;
      win_valid_q  <= win_valid_d;
      select_q     <= select_d;
      win_last_q   <= win_last_d;
      frame_done_q <= frame_done_d;
    end
  end

  assign in_ready   = in_ready_q;
  assign win_valid  = win_valid_q;
  assign select     = select_q;
  assign win_last   = win_last_q;
  assign frame_done = frame_done_q;

  assign tl_d = w_q[0][0];
  assign t_d  = w_q[0][1];
  assign tr_d = w_q[0][2];
  assign l_d  = w_q[1][0];
  assign c_d  = w_q[1][1];
  assign r_d  = w_q[1][2];
  assign bl_d = w_q[2][0];
  assign b_d  = w_q[2][1];
  assign br_d = w_q[2][2];

endmodule
